// File: rtl/test_pipe_delay_if.sv
// Valid/ready message channel shared by the input and output sides of the delay element.
// master drives val/msg and samples rdy; slave does the reverse.
interface test_pipe_delay_if #(
  parameter int p_msg_nbits = 1
);
  logic                   val;
  logic                   rdy;
  logic [p_msg_nbits-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/test_pipe_delay.sv
// Buffered per-message delay line: each message leaves no earlier than its fixed or LFSR-masked delay, in FIFO order.
// Latency d cycles (0 via same-cycle bypass when empty); in_rdy drops only when all p_num_entries slots are occupied.
module test_pipe_delay #(
  parameter int          p_msg_nbits   = 1,
  parameter int          p_num_entries = 4,
  parameter logic [15:0] p_lfsr_seed   = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               mode,
  input  logic [31:0]                        delay_amt,
  test_pipe_delay_if.slave                   in_if,
  test_pipe_delay_if.master                  out_if,
  output logic [$clog2(p_num_entries+1)-1:0] count
);
  localparam int            PW        = $clog2(p_num_entries);
  localparam int            CW        = $clog2(p_num_entries + 1);
  localparam logic [CW-1:0] FULL      = CW'(p_num_entries);
  localparam logic [15:0]   LFSR_MASK = 16'hB400;

  logic [p_msg_nbits-1:0]   msg_q   [p_num_entries];
  logic [31:0]              timer_q [p_num_entries];
  logic [31:0]              timer_d [p_num_entries];
  logic [p_num_entries-1:0] vld_q, vld_d;
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic [15:0]              lfsr_q, lfsr_d, lfsr_step;
  logic [31:0]              eff_dly;
  logic                     head_rdy, bypass, enq, deq, enq_store, deq_store;

  assign eff_dly   = mode ? ({16'h0000, lfsr_q} & delay_amt) : delay_amt;
  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  assign head_rdy  = vld_q[head_q] && (timer_q[head_q] == 32'd0);

  // Zero-delay message into an empty buffer with a ready sink skips storage entirely.
  assign bypass    = !reset && (count_q == '0) && in_if.val && out_if.rdy && (eff_dly == 32'd0);

  assign in_if.rdy  = !reset && (count_q != FULL);
  assign out_if.val = !reset && (head_rdy || bypass);
  assign out_if.msg = bypass ? in_if.msg : msg_q[head_q];
  assign count      = count_q;

  assign enq       = in_if.val && in_if.rdy;
  assign deq       = out_if.val && out_if.rdy;
  assign enq_store = enq && !bypass;
  assign deq_store = deq && !bypass;

  always_comb begin
    lfsr_d  = lfsr_q;
    head_d  = head_q;
    tail_d  = tail_q;
    vld_d   = vld_q;
    count_d = count_q;
    timer_d = timer_q;

    // Every waiting entry counts down regardless of its queue position or the sink.
    for (int i = 0; i < p_num_entries; i++) begin
      if (vld_q[i] && (timer_q[i] != 32'd0)) begin
        timer_d[i] = timer_q[i] - 32'd1;
      end
    end

    if (enq) begin
      lfsr_d = lfsr_step;
    end

    if (deq_store) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end

    if (enq_store) begin
      vld_d[tail_q]   = 1'b1;
      timer_d[tail_q] = (eff_dly == 32'd0) ? 32'd0 : (eff_dly - 32'd1);
      tail_d          = tail_q + 1'b1;
    end

    unique case ({enq_store, deq_store})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      vld_q   <= '0;
      count_q <= '0;
      lfsr_q  <= p_lfsr_seed;
      for (int i = 0; i < p_num_entries; i++) begin
        timer_q[i] <= 32'd0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      vld_q   <= vld_d;
      count_q <= count_d;
      lfsr_q  <= lfsr_d;
      timer_q <= timer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_store) begin
      msg_q[tail_q] <= in_if.msg;
    end
  end

  a_no_x: assert property (@(posedge clk) disable iff (reset)
    !$isunknown({in_if.val, out_if.rdy, mode, delay_amt, in_if.rdy, out_if.val}));

endmodule

// File: tb/tb_test_pipe_delay.sv
// Scenario tasks plus a cycle-level scoreboard for test_pipe_delay.
module tb_test_pipe_delay;
  localparam int          W    = 8;
  localparam int          N    = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        mode      = 1'b0;
  logic [31:0] delay_amt = 32'd0;
  logic [2:0]  count;

  test_pipe_delay_if #(.p_msg_nbits(W)) in_if ();
  test_pipe_delay_if #(.p_msg_nbits(W)) out_if ();

  test_pipe_delay #(.p_msg_nbits(W), .p_num_entries(N), .p_lfsr_seed(SEED)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .delay_amt (delay_amt),
    .in_if     (in_if),
    .out_if    (out_if),
    .count     (count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] msg;
    int         due;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_lfsr = SEED;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Scoreboard: entries carry the absolute cycle at which they become eligible to leave.
  always @(negedge clk) begin : sb
    logic [31:0] d;
    logic [7:0]  em;
    bit          byp, ev, er;
    if (reset) begin
      vectors++;
      if (out_if.val !== 1'b0 || in_if.rdy !== 1'b0) begin
        miscompares++;
        $display("FAIL sb_in_reset: out_val=%b in_rdy=%b, required 0/0", out_if.val, in_if.rdy);
      end
      exp_q.delete();
      m_lfsr = SEED;
    end else begin
      d   = mode ? ({16'h0000, m_lfsr} & delay_amt) : delay_amt;
      byp = (exp_q.size() == 0) && in_if.val && out_if.rdy && (d == 32'd0);
      ev  = byp || ((exp_q.size() != 0) && (exp_q[0].due <= cyc));
      er  = exp_q.size() < N;
      vectors++;
      if (out_if.val !== ev) begin
        miscompares++;
        $display("FAIL sb_out_val cyc %0d: got %b, required %b", cyc, out_if.val, ev);
      end
      if (ev) begin
        em = byp ? in_if.msg : exp_q[0].msg;
        vectors++;
        if (out_if.msg !== em) begin
          miscompares++;
          $display("FAIL sb_out_msg cyc %0d: got %h, required %h", cyc, out_if.msg, em);
        end
      end
      vectors++;
      if (in_if.rdy !== er) begin
        miscompares++;
        $display("FAIL sb_in_rdy cyc %0d: got %b, required %b", cyc, in_if.rdy, er);
      end
      vectors++;
      if (count !== 3'(exp_q.size())) begin
        miscompares++;
        $display("FAIL sb_count cyc %0d: got %0d, required %0d", cyc, count, exp_q.size());
      end
      if (ev && out_if.rdy && !byp) void'(exp_q.pop_front());
      if (er && in_if.val) begin
        m_lfsr = lfsr_next(m_lfsr);
        if (!byp) exp_q.push_back('{msg: in_if.msg, due: cyc + ((d == 32'd0) ? 1 : int'(d))});
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset     = 1'b1;
    in_if.val = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset      = 1'b1;
    in_if.val  = 1'b0;
    out_if.rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_if.val !== 1'b0) begin miscompares++; $display("FAIL reset_out_val: got %b, required 0", out_if.val); end
    vectors++;
    if (in_if.rdy !== 1'b0) begin miscompares++; $display("FAIL reset_in_rdy: got %b, required 0", in_if.rdy); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_if.rdy !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_rdy: got %b, required 1", in_if.rdy); end
    vectors++;
    if (out_if.val !== 1'b0) begin miscompares++; $display("FAIL post_reset_out_val: got %b, required 0", out_if.val); end
    vectors++;
    if (count !== 3'd0) begin miscompares++; $display("FAIL post_reset_count: got %0d, required 0", count); end
  endtask

  task automatic test_bypass();
    @(posedge clk); #1;
    mode = 1'b0; delay_amt = 32'd0; out_if.rdy = 1'b1;
    in_if.val = 1'b1; in_if.msg = 8'h5A;
    @(negedge clk);
    vectors++;
    if (out_if.val !== 1'b1 || out_if.msg !== 8'h5A) begin
      miscompares++;
      $display("FAIL bypass_out: got val=%b msg=%h, required val=1 msg=5a", out_if.val, out_if.msg);
    end
    vectors++;
    if (count !== 3'd0) begin miscompares++; $display("FAIL bypass_count: got %0d, required 0", count); end
    @(posedge clk); #1;
    in_if.val = 1'b0;
    @(negedge clk);
    vectors++;
    if (count !== 3'd0 || out_if.val !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_after: got count=%0d out_val=%b, required 0/0", count, out_if.val);
    end
  endtask

  task automatic test_pipelined();
    int t = 0, got = 0, maxc = 0;
    int         oc[4];
    logic [7:0] om[4];
    for (int i = 0; i < 4; i++) begin oc[i] = -1; om[i] = 8'h00; end
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      mode = 1'b0; delay_amt = 32'd3; out_if.rdy = 1'b1;
      in_if.val = (k < 4);
      in_if.msg = 8'(k + 1);
      @(negedge clk);
      if (k == 0) t = cyc;
      if (int'(count) > maxc) maxc = int'(count);
      if (out_if.val && got < 4) begin oc[got] = cyc; om[got] = out_if.msg; got++; end
    end
    vectors++;
    if (got !== 4) begin miscompares++; $display("FAIL pipe_num_out: got %0d, required 4", got); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (om[i] !== 8'(i + 1) || oc[i] !== t + 3 + i) begin
        miscompares++;
        $display("FAIL pipe_out%0d: got msg=%h cyc=%0d, required msg=%h cyc=%0d", i, om[i], oc[i], 8'(i + 1), t + 3 + i);
      end
    end
    vectors++;
    if (maxc !== 3) begin miscompares++; $display("FAIL pipe_max_count: got %0d, required 3", maxc); end
  endtask

  task automatic test_full();
    int         nxt = 1, r = 0, acc5 = -1;
    logic [7:0] dm[$];
    int         dc[$];
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      mode = 1'b0; delay_amt = 32'd1; out_if.rdy = 1'b0;
      in_if.val = 1'b1; in_if.msg = 8'(16 + nxt);
      @(negedge clk);
      if (in_if.rdy) nxt++;
    end
    vectors++;
    if (nxt !== 5) begin miscompares++; $display("FAIL full_accepted: got %0d, required 4", nxt - 1); end
    vectors++;
    if (count !== 3'd4 || in_if.rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_state: got count=%0d in_rdy=%b, required 4/0", count, in_if.rdy);
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      out_if.rdy = 1'b1;
      in_if.val  = (nxt <= 5);
      in_if.msg  = 8'(16 + nxt);
      @(negedge clk);
      if (k == 0) r = cyc;
      if (out_if.val) begin dm.push_back(out_if.msg); dc.push_back(cyc); end
      if (in_if.val && in_if.rdy) begin
        if (nxt == 5) acc5 = cyc;
        nxt++;
      end
    end
    vectors++;
    if (acc5 !== r + 1) begin miscompares++; $display("FAIL full_fifth_accept: got cyc %0d, required %0d", acc5, r + 1); end
    vectors++;
    if (dm.size() !== 5) begin miscompares++; $display("FAIL full_num_out: got %0d, required 5", dm.size()); end
    for (int i = 0; i < 5 && i < dm.size(); i++) begin
      vectors++;
      if (dm[i] !== 8'(17 + i) || dc[i] !== r + i) begin
        miscompares++;
        $display("FAIL full_out%0d: got msg=%h cyc=%0d, required msg=%h cyc=%0d", i, dm[i], dc[i], 8'(17 + i), r + i);
      end
    end
  endtask

  task automatic test_random();
    int          lats[2][20];
    int          t, lat, gl, diff;
    logic [15:0] g;
    logic [7:0]  m, om;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      g = SEED;
      for (int i = 0; i < 20; i++) begin
        gl = int'(g & 16'h0007);
        g  = lfsr_next(g);
        m  = 8'(8'h80 + i);
        @(posedge clk); #1;
        mode = 1'b1; delay_amt = 32'h7; out_if.rdy = 1'b1;
        in_if.val = 1'b1; in_if.msg = m;
        @(negedge clk);
        t = cyc; lat = -1; om = 8'h00;
        if (out_if.val) begin lat = 0; om = out_if.msg; end
        @(posedge clk); #1;
        in_if.val = 1'b0;
        for (int w = 0; w < 12 && lat < 0; w++) begin
          @(negedge clk);
          if (out_if.val) begin lat = cyc - t; om = out_if.msg; end
        end
        lats[run][i] = lat;
        vectors++;
        if (lat !== gl || lat > 7) begin
          miscompares++;
          $display("FAIL rand_lat run%0d msg%0d: got %0d, required %0d", run, i, lat, gl);
        end
        vectors++;
        if (om !== m) begin miscompares++; $display("FAIL rand_msg run%0d msg%0d: got %h, required %h", run, i, om, m); end
      end
    end
    diff = 0;
    for (int i = 0; i < 20; i++) if (lats[0][i] !== lats[1][i]) diff++;
    vectors++;
    if (diff !== 0) begin miscompares++; $display("FAIL rand_repeat: got %0d differing latencies, required 0", diff); end
  endtask

  task automatic test_reset_midflight();
    int stale = 0, t = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      mode = 1'b0; delay_amt = 32'd10; out_if.rdy = 1'b1;
      in_if.val = 1'b1; in_if.msg = 8'(8'hA0 + k);
    end
    @(posedge clk); #1;
    in_if.val = 1'b0; reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_if.val !== 1'b0 || in_if.rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got out_val=%b in_rdy=%b, required 0/0", out_if.val, in_if.rdy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (count !== 3'd0 || out_if.val !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_state: got count=%0d out_val=%b, required 0/0", count, out_if.val);
    end
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (out_if.val) stale++;
    end
    vectors++;
    if (stale !== 0) begin miscompares++; $display("FAIL mid_reset_stale: got %0d outputs, required 0", stale); end
    // Seed 0xACE1 masked with 0xF yields a one-cycle delay.
    @(posedge clk); #1;
    mode = 1'b1; delay_amt = 32'hF; in_if.val = 1'b1; in_if.msg = 8'h3C;
    @(negedge clk);
    t = cyc;
    vectors++;
    if (out_if.val !== 1'b0) begin miscompares++; $display("FAIL mid_seed_early: got out_val=%b, required 0", out_if.val); end
    @(posedge clk); #1;
    in_if.val = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_if.val !== 1'b1 || out_if.msg !== 8'h3C || cyc !== t + 1) begin
      miscompares++;
      $display("FAIL mid_seed_delay: got val=%b msg=%h, required val=1 msg=3c", out_if.val, out_if.msg);
    end
  endtask

  task automatic test_param_change();
    int t = 0, c55 = -1, c66 = -1;
    @(posedge clk); #1;
    mode = 1'b0; delay_amt = 32'd5; out_if.rdy = 1'b1;
    in_if.val = 1'b1; in_if.msg = 8'h55;
    @(negedge clk);
    t = cyc;
    @(posedge clk); #1;
    delay_amt = 32'd0; in_if.msg = 8'h66;
    @(negedge clk);
    vectors++;
    if (out_if.val !== 1'b0) begin miscompares++; $display("FAIL param_no_bypass: got out_val=%b, required 0", out_if.val); end
    @(posedge clk); #1;
    in_if.val = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_if.val && out_if.msg === 8'h55 && c55 < 0) c55 = cyc;
      if (out_if.val && out_if.msg === 8'h66 && c66 < 0) c66 = cyc;
    end
    vectors++;
    if (c55 !== t + 5) begin miscompares++; $display("FAIL param_old_exit: got cyc %0d, required %0d", c55, t + 5); end
    vectors++;
    if (c66 !== t + 6) begin miscompares++; $display("FAIL param_new_exit: got cyc %0d, required %0d", c66, t + 6); end
  endtask

  initial begin
    in_if.val  = 1'b0;
    in_if.msg  = 8'h00;
    out_if.rdy = 1'b0;
    test_reset();
    test_bypass();
    test_pipelined();
    test_full();
    test_random();
    test_reset_midflight();
    test_param_change();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/test_pipe_delay.md
# test_pipe_delay

Parametrised, buffered test-harness delay element that sits between a test source/sink and the design under test. It holds up to `p_num_entries` messages in flight at once. Each message is delivered no earlier than its own per-message delay after acceptance, in strict FIFO order. Delays are pipelined rather than serialised, and each delay is either fixed or pseudo-random (LFSR-masked), selectable at runtime.

## Interface
- `p_msg_nbits`, 1, message width in bits
- `p_num_entries`, 4, in-flight capacity; power of two, ≥2
- `p_lfsr_seed`, 16'hACE1, LFSR reset value; must be nonzero

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `mode`  in  1  0 = fixed delay, 1 = random delay; sampled only at enqueue
- `delay_amt`  in  32  fixed delay (mode 0) or delay mask (mode 1); sampled only at enqueue
- `in_val`  in  1  input message valid
- `in_rdy`  out  1  input ready
- `in_msg`  in  `p_msg_nbits`  input message
- `out_val`  out  1  output message valid
- `out_rdy`  in  1  output ready
- `out_msg`  out  `p_msg_nbits`  output message; don't-care when `out_val` is 0
- `count`  out  `$clog2(p_num_entries+1)`  number of stored entries

## Operation
- Storage is a circular buffer of `p_num_entries` slots. Each slot holds a message and a 32-bit timer.
- Head and tail pointers wrap modulo `p_num_entries`.
- Enqueue fires when `in_val && in_rdy`. Dequeue fires when `out_val && out_rdy`.
- Effective delay d is computed combinationally in the enqueue cycle:
  - Mode 0: d = `delay_amt`.
  - Mode 1: d = {16'b0, lfsr} & `delay_amt`.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Shifts right by one on every enqueue, including bypass.
  - Does not advance otherwise.
  - When bit0=1 the shifted value is XORed with the mask.
- On enqueue, the slot timer is loaded with d−1 if d>0, else 0.
- Every valid slot's timer decrements by 1 each cycle, saturating at 0. Decrement is independent of `out_rdy` and head position.
- `out_val` = head valid && head timer==0, or bypass. `out_msg` = head message, or `in_msg` on bypass.
- Bypass (zero-cycle path) applies when all of the following hold: count==0, `in_val`, `out_rdy`, d==0.
  - In bypass, the message goes straight to the output in the same cycle.
  - Nothing is stored and count is unchanged.
  - If count==0 and d==0 but `out_rdy`=0, the message is stored with timer 0.
- `in_rdy` = (count < `p_num_entries`). When full, `in_rdy` is 0 even if a dequeue occurs the same cycle.
- Simultaneous non-bypass enqueue and dequeue leaves count unchanged. Tail and head both advance.
- Delivery is strictly in order. A younger entry whose timer reaches 0 waits behind the head.
- Changes to `mode` or `delay_amt` after enqueue do not affect stored entries.

## Timing
- Reset, including mid-operation: all entries are discarded.
  - count=0, pointers=0, lfsr=`p_lfsr_seed`.
  - While reset is high: `out_val`=0 and `in_rdy`=0.
  - The first cycle after reset: `in_rdy`=1 and `out_val` follows bypass only.
- Entry enqueued in cycle t with d≥1: earliest `out_val` in cycle t+d.
- Entry enqueued in cycle t with d=0, not bypassed: earliest `out_val` in cycle t+1.
- Back-to-back enqueues with equal d drain one per cycle, d cycles later. Throughput is 1 message/cycle.
- `in_rdy`, `out_val`, `out_msg` are combinational from state plus `in_val`/`out_rdy`/`delay_amt`/`mode`. There are no other comb paths.
- Assert no X on `in_val`, `out_rdy`, `mode`, `delay_amt`, `in_rdy`, `out_val` while reset is low.
- Line trace format: in val/rdy/msg `|` out val/rdy/msg.

## Test plan
- Bypass: mode 0, `delay_amt`=0, empty, `out_rdy`=1, `in_msg`=0x5A in cycle t -> `out_val`=1 and `out_msg`=0x5A in cycle t; count stays 0.
- Pipelined fixed delay: mode 0, `delay_amt`=3, enqueue 0x01..0x04 in cycles t..t+3, `out_rdy`=1 -> outputs 0x01..0x04 in cycles t+3..t+6; max count=3.
- Full/backpressure (`p_num_entries`=4): `out_rdy`=0, present 5 messages, `delay_amt`=1 -> 4 accepted, count=4, `in_rdy`=0; raise `out_rdy` -> 4 dequeued in order, one per cycle; 5th accepted the cycle after the first dequeue; no loss or duplication.
- Random mode: mode 1, `delay_amt`=0x7, 20 messages with `out_rdy`=1 -> each latency equals the golden LFSR model's (lfsr & 7), all ≤7, order preserved; a repeat run after reset gives an identical sequence.
- Reset mid-flight: 3 entries stored with `delay_amt`=10, assert reset one cycle -> count=0, `out_val`=0, old messages never appear; next enqueue uses the seed-derived delay.
- Parameter change in flight: enqueue with `delay_amt`=5, set `delay_amt`=0 next cycle -> stored entry still exits at t+5; a new message with d=0 waits behind it (no bypass, since count≠0).
